tone_shaper: RTL

TONE_SHAPER -- requirements
Module: tone_shaper

---
 rtl/tone_shaper.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tone_shaper.sv
// Tone envelope and waveform shaper: tracks oscillator phase, holds full volume while
// steps arrive, fades out after a quiet period, and drives a scaled sample plus PWM.
module tone_shaper #(
   parameter int IDLE_TIMEOUT = 1024,
   parameter int FADE_STEP    = 256
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       step,
   input  logic [1:0] wave_sel,
   input  logic       mute,
   output logic [7:0] sample,
   output logic       pwm_out,
   output logic       busy
);

   localparam int GAP_W  = $clog2(IDLE_TIMEOUT + 1);
   localparam int FADE_W = $clog2(FADE_STEP + 1);
   localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(IDLE_TIMEOUT - 1);
   localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_STEP - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_FADE = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [7:0]        phase_q,   phase_d;
   logic [3:0]        vol_q,     vol_d;
   logic [GAP_W-1:0]  gap_q,     gap_d;
   logic [FADE_W-1:0] fade_q,    fade_d;
   logic [7:0]        pwm_cnt_q, pwm_cnt_d;
   logic [7:0]        sample_q,  sample_d;
   logic              pwm_out_q, pwm_out_d;
   logic              busy_q,    busy_d;

   function automatic logic [7:0] wave_value(input logic [7:0] p, input logic [1:0] sel);
      case (sel)
         2'd0:    wave_value = p[7] ? 8'hFF : 8'h00;
         2'd1:    wave_value = p;
         2'd2:    wave_value = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
         default: wave_value = 8'h00;
      endcase
   endfunction

   // Full 12-bit product keeps the top bits; dropping the low nibble divides by 16.
   function automatic logic [7:0] scale_amp(input logic [7:0] w, input logic [3:0] v);
      logic [11:0] prod;
      prod      = {4'b0, w} * {8'b0, v};
      scale_amp = prod[11:4];
   endfunction

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      vol_d     = vol_q;
      gap_d     = gap_q;
      fade_d    = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;

      if (step) begin
         gap_d = '0;
      end else if (gap_q != GAP_MAX) begin
         gap_d = gap_q + 1'b1;
      end

      // A step always wins, even over a fade decrement landing on the same cycle.
      if (step) begin
         phase_d = phase_q + 8'd1;
         state_d = ST_PLAY;
         vol_d   = 4'd15;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (gap_q == GAP_MAX) state_d = ST_FADE;
            end
            ST_FADE: begin
               if (fade_q == FADE_MAX) begin
                  vol_d = vol_q - 4'd1;
                  if (vol_q == 4'd1) begin
                     state_d = ST_IDLE;
                     phase_d = 8'd0;
                  end
               end else begin
                  fade_d = fade_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (mute || state_q == ST_IDLE || wave_sel == 2'd3) begin
         sample_d = 8'd0;
      end else begin
         sample_d = scale_amp(wave_value(phase_q, wave_sel), vol_q);
      end

      pwm_out_d = (pwm_cnt_q < sample_q);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         vol_q     <= '0;
         gap_q     <= '0;
         fade_q    <= '0;
         pwm_cnt_q <= '0;
         sample_q  <= '0;
         pwm_out_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         vol_q     <= vol_d;
         gap_q     <= gap_d;
         fade_q    <= fade_d;
         pwm_cnt_q <= pwm_cnt_d;
         sample_q  <= sample_d;
         pwm_out_q <= pwm_out_d;
         busy_q    <= busy_d;
      end
   end

   assign sample  = sample_q;
   assign pwm_out = pwm_out_q;
   assign busy    = busy_q;

endmodule
